// File: rtl/hpdcache_gnt_mux_pkg.sv
// Shared types and helpers for the grant-driven payload mux.
// Buffer state encoding and one-hot to index conversion.
package hpdcache_gnt_mux_pkg;

  localparam int unsigned MAX_N = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  function automatic int unsigned onehot_to_idx(
    input logic [MAX_N-1:0] v
  );
    int unsigned idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hpdcache_fifo2.sv
// Generic 2-entry registered FIFO with async active-high reset.
// Head is always a register, so rdata never glitches on push.
module hpdcache_fifo2
  import hpdcache_gnt_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // State and entry registers; reset discards all entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state: push lands in head when it is free, else tail.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = wdata_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push_i && pop_i) begin
          head_d = wdata_i;
        end else if (push_i) begin
          tail_d  = wdata_i;
          state_d = FULL;
        end else if (pop_i) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_i) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign rdata_o = head_q;
  assign valid_o = (state_q != EMPTY);
  assign full_o  = (state_q == FULL);

endmodule

// File: rtl/hpdcache_gnt_mux_buf.sv
// Grant mux feeding a 2-entry output buffer behind the arbiter.
// Optional source index: define HPDCACHE_GNT_MUX_SRC_ID_EN.
module hpdcache_gnt_mux_buf
  import hpdcache_gnt_mux_pkg::*;
#(
  parameter  int unsigned N  = 2,
  parameter  int unsigned W  = 32,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_valid_i,
  input  logic [N*W-1:0] req_data_i,
  output logic [N-1:0]   req_ready_o,
  input  logic [N-1:0]   gnt_i,
  output logic           arb_ready_o,
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
`ifdef HPDCACHE_GNT_MUX_SRC_ID_EN
  output logic [SW-1:0]  out_src_o,
`endif
  input  logic           out_ready_i
);

`ifdef HPDCACHE_GNT_MUX_SRC_ID_EN
  localparam int unsigned FW = W + SW;
`else
  localparam int unsigned FW = W;
`endif

  logic [N-1:0]  sel;
  logic [N-1:0]  sel_low;
  logic [W-1:0]  mux_data;
  logic          full;
  logic          push;
  logic          pop;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;

  assign sel     = gnt_i & req_valid_i;
  assign sel_low = sel & (~sel + N'(1));

  // Payload of the lowest granted-and-valid requester.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_low[k]) mux_data = req_data_i[k*W +: W];
    end
  end

  assign push = (|sel) & ~full & ~rst_i;
  assign pop  = out_valid_o & out_ready_i;

  assign req_ready_o = rst_i ? '0 : (sel_low & {N{~full}});
  assign arb_ready_o = push;

`ifdef HPDCACHE_GNT_MUX_SRC_ID_EN
  logic [SW-1:0] src_idx;
  assign src_idx = SW'(onehot_to_idx(MAX_N'(sel)));
  assign wdata   = {src_idx, mux_data};
  assign out_src_o  = rdata[W +: SW];
`else
  assign wdata   = mux_data;
`endif
  assign out_data_o = rdata[W-1:0];

  hpdcache_fifo2 #(
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .valid_o (out_valid_o),
    .full_o  (full)
  );

  // The arbiter must never present more than one grant.
  a_gnt_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(gnt_i)
  );

endmodule

// File: tb/tb_hpdcache_gnt_mux_buf.sv
// Scoreboard bench for hpdcache_gnt_mux_buf, N=4, W=32.
// Stimulus pushes expected entries; a monitor pops and compares.
module tb_hpdcache_gnt_mux_buf;

  logic         clk;
  logic         rst;
  logic [3:0]   vld;
  logic [31:0]  d [4];
  logic [127:0] req_data;
  logic [3:0]   rr;
  logic [3:0]   gnt;
  logic         arb;
  logic         ovld;
  logic [31:0]  odata;
  logic [1:0]   osrc;
  logic         ordy;

  int checks;
  int errors;
  logic [33:0] exp_q[$];

  assign req_data = {d[3], d[2], d[1], d[0]};

  hpdcache_gnt_mux_buf #(
    .N (4),
    .W (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (vld),
    .req_data_i  (req_data),
    .req_ready_o (rr),
    .gnt_i       (gnt),
    .arb_ready_o (arb),
    .out_valid_o (ovld),
    .out_data_o  (odata),
`ifdef HPDCACHE_GNT_MUX_SRC_ID_EN
    .out_src_o   (osrc),
`endif
    .out_ready_i (ordy)
  );

`ifndef HPDCACHE_GNT_MUX_SRC_ID_EN
  assign osrc = 2'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step(input logic [3:0] g, input logic [3:0] v,
                      input logic r, input logic ea,
                      input logic [3:0] er, input logic [31:0] ed,
                      input logic [1:0] es);
    gnt  = g;
    vld  = v;
    ordy = r;
    @(negedge clk);
    chk("arb_ready", 32'(arb), 32'(ea));
    chk("req_ready", 32'(rr), 32'(er));
    if (ea) exp_q.push_back({es, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 4'b0, 1'b1, 1'b0, 4'b0, 32'h0, 2'd0);
  endtask

  // Head must match the oldest expected entry; pop it on accept.
  always @(negedge clk) begin
    if (!rst && ovld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid got data %h want none", odata);
      end else begin
        chk("out_data", odata, exp_q[0][31:0]);
`ifdef HPDCACHE_GNT_MUX_SRC_ID_EN
        chk("out_src", 32'(osrc), 32'(exp_q[0][33:32]));
`endif
        if (ordy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    gnt  = 4'b0100;
    vld  = 4'b0100;
    ordy = 1'b1;
    for (int k = 0; k < 4; k++) d[k] = 32'h0;
    #3;
    chk("rst_out_valid", 32'(ovld), 32'h0);
    chk("rst_out_data", odata, 32'h0);
    chk("rst_out_src", 32'(osrc), 32'h0);
    chk("rst_req_ready", 32'(rr), 32'h0);
    chk("rst_arb_ready", 32'(arb), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single transfer from requester 2.
    d[2] = 32'hCAFE0002;
    step(4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 32'hCAFE0002, 2'd2);
    chk("lat_out_valid", 32'(ovld), 32'h1);
    idle(2);

    // Backpressure: fill, hold grant, then drain in order.
    d[0] = 32'hAAAA0000;
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 32'hAAAA0000, 2'd0);
    d[0] = 32'hBBBB0000;
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 32'hBBBB0000, 2'd0);
    d[0] = 32'hCCCC0000;
    step(4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0);
    step(4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0);
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 32'hCCCC0000, 2'd0);
    idle(3);

    // Streaming with rotating grant.
    for (int k = 0; k < 4; k++) d[k] = 32'h11110000 | 32'(k);
    step(4'b0001, 4'b1111, 1'b1, 1'b1, 4'b0001, 32'h11110000, 2'd0);
    step(4'b0010, 4'b1111, 1'b1, 1'b1, 4'b0010, 32'h11110001, 2'd1);
    step(4'b0100, 4'b1111, 1'b1, 1'b1, 4'b0100, 32'h11110002, 2'd2);
    step(4'b1000, 4'b1111, 1'b1, 1'b1, 4'b1000, 32'h11110003, 2'd3);
    idle(3);
    chk("stream_drained", 32'(exp_q.size()), 32'h0);

    // Invalid grant leaves buffer untouched.
    d[0] = 32'h55550000;
    d[1] = 32'h55550001;
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 32'h55550000, 2'd0);
    step(4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0);
    step(4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0);
    chk("inv_held_valid", 32'(ovld), 32'h1);
    idle(2);
    chk("inv_drained", 32'(ovld), 32'h0);

    // Asynchronous reset while full.
    d[3] = 32'hDEAD0003;
    step(4'b1000, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'hDEAD0003, 2'd3);
    step(4'b1000, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'hDEAD0003, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_out_valid", 32'(ovld), 32'h0);
    chk("arst_req_ready", 32'(rr), 32'h0);
    chk("arst_arb_ready", 32'(arb), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d[1] = 32'hBEEF0001;
    step(4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 32'hBEEF0001, 2'd1);
    chk("post_rst_valid", 32'(ovld), 32'h1);
    idle(3);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
